// File: rtl/sipo_frame_deserializer.sv
// Serial-in/parallel-out receive shifter with runtime frame length, a
// valid/ready output holding register and sticky overrun detection.
module sipo_frame_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             clear,
  output logic [WIDTH-1:0] shift_q,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun
);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] len_q, len_d, eff_len, cur_len, pos;
  logic [WIDTH-1:0] dout_q, dout_d, frame;
  logic             valid_q, valid_d, ovr_q, ovr_d;
  logic             take, last, accept, load, drop;

  assign bit_count  = cnt_q;
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

  // Bit placement and completion decode; the first bit of a frame uses the live length.
  always_comb begin
    eff_len = ((frame_len == '0) || (frame_len > CNT_W'(WIDTH))) ? CNT_W'(WIDTH) : frame_len;
    cur_len = (state_q == StIdle) ? eff_len : len_q;
    pos     = LSB_FIRST ? cnt_q : (cur_len - cnt_q - CNT_W'(1));
    cnt_inc = cnt_q + CNT_W'(1);
    take    = bit_valid & ~clear;
    last    = take & (cnt_inc == cur_len);
    frame   = (state_q == StIdle) ? '0 : shift_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (CNT_W'(i) == pos) frame[i] = bit_in;
    end
    accept  = valid_q & data_ready;
    load    = last & (~valid_q | data_ready);
    drop    = last & valid_q & ~data_ready;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else if (bit_valid) begin
      state_d = last ? StIdle : StCollect;
    end
  end

  always_comb begin
    busy = (state_q == StCollect);
  end

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    len_d   = len_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
      ovr_d   = 1'b0;
    end else if (take) begin
      if (state_q == StIdle) len_d = eff_len;
      if (last) begin
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        cnt_d   = cnt_inc;
        shift_d = frame;
      end
    end
    if (load) begin
      dout_d  = frame;
      valid_d = 1'b1;
    end else begin
      if (accept) valid_d = 1'b0;
      if (drop)   ovr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Bench for sipo_frame_deserializer: LSB-first and MSB-first instances share stimulus and
// are checked every cycle against a queue-based frame model plus directed expectations.
module tb_sipo_frame_deserializer;

  logic       clk, reset, bit_in, bit_valid, clear, data_ready;
  logic [3:0] frame_len;
  logic [7:0] sq_l, sq_m, dout_l, dout_m;
  logic [3:0] cnt_l, cnt_m;
  logic       busy_l, busy_m, dv_l, dv_m, ovr_l, ovr_m;

  int checks = 0;
  int errors = 0;

  sipo_frame_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_len(frame_len), .clear(clear), .shift_q(sq_l), .bit_count(cnt_l),
    .busy(busy_l), .data_out(dout_l), .data_valid(dv_l), .data_ready(data_ready),
    .overrun(ovr_l)
  );

  sipo_frame_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_len(frame_len), .clear(clear), .shift_q(sq_m), .bit_count(cnt_m),
    .busy(busy_m), .data_out(dout_m), .data_valid(dv_m), .data_ready(data_ready),
    .overrun(ovr_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: received bits of the partial frame, latched length, holding register.
  bit         mq[$];
  int         m_len = 0;
  logic [7:0] m_dout_l = '0, m_dout_m = '0;
  logic       m_dv = 1'b0, m_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] place(input bit lsb, input int len);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < mq.size(); k++) begin
      if (mq[k]) v = v | (8'(1) << (lsb ? k : len - 1 - k));
    end
    return v;
  endfunction

  task automatic model_step();
    bit         done;
    logic [7:0] f_l, f_m;
    done = 1'b0;
    f_l  = '0;
    f_m  = '0;
    if (reset) begin
      mq.delete();
      m_len    = 0;
      m_dout_l = '0;
      m_dout_m = '0;
      m_dv     = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      if (clear) begin
        mq.delete();
        m_ovr = 1'b0;
      end else if (bit_valid) begin
        if (mq.size() == 0) m_len = (frame_len == 0 || frame_len > 8) ? 8 : int'(frame_len);
        mq.push_back(bit_in);
        if (mq.size() == m_len) begin
          done = 1'b1;
          f_l  = place(1'b1, m_len);
          f_m  = place(1'b0, m_len);
          mq.delete();
        end
      end
      if (done) begin
        if (m_dv && !data_ready) begin
          m_ovr = 1'b1;
        end else begin
          m_dout_l = f_l;
          m_dout_m = f_m;
          m_dv     = 1'b1;
        end
      end else if (m_dv && data_ready) begin
        m_dv = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    chk("model lsb shift_q", 32'(sq_l), 32'(place(1'b1, m_len)));
    chk("model msb shift_q", 32'(sq_m), 32'(place(1'b0, m_len)));
    chk("model lsb bit_count", 32'(cnt_l), mq.size());
    chk("model msb bit_count", 32'(cnt_m), mq.size());
    chk("model lsb busy", 32'(busy_l), 32'(mq.size() != 0));
    chk("model msb busy", 32'(busy_m), 32'(mq.size() != 0));
    chk("model lsb data_out", 32'(dout_l), 32'(m_dout_l));
    chk("model msb data_out", 32'(dout_m), 32'(m_dout_m));
    chk("model lsb data_valid", 32'(dv_l), 32'(m_dv));
    chk("model msb data_valid", 32'(dv_m), 32'(m_dv));
    chk("model lsb overrun", 32'(ovr_l), 32'(m_ovr));
    chk("model msb overrun", 32'(ovr_m), 32'(m_ovr));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle();
    reset      = 1'b0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    clear      = 1'b0;
    data_ready = 1'b0;
  endtask

  task automatic send_bits(input logic [3:0] fl, input logic [31:0] val, input int n);
    for (int k = 0; k < n; k++) begin
      frame_len = fl;
      bit_in    = val[k];
      bit_valid = 1'b1;
      cycle();
    end
    bit_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " lsb shift_q"}, 32'(sq_l), 0);
    chk({tag, " msb shift_q"}, 32'(sq_m), 0);
    chk({tag, " bit_count"}, 32'(cnt_l), 0);
    chk({tag, " busy"}, 32'(busy_l), 0);
    chk({tag, " lsb data_out"}, 32'(dout_l), 0);
    chk({tag, " msb data_out"}, 32'(dout_m), 0);
    chk({tag, " data_valid"}, 32'(dv_l), 0);
    chk({tag, " overrun"}, 32'(ovr_l), 0);
  endtask

  typedef struct {
    logic [3:0] fl;
    logic [7:0] val;
    logic       rdy_last;
    logic       clr_before;
    logic       pop;
    logic [7:0] e_l;
    logic [7:0] e_m;
    logic       e_ovr;
  } vec_t;

  vec_t tbl[9];
  int   len_eff;

  initial begin
    tbl[0] = '{fl: 4'd8, val: 8'hA5, rdy_last: 0, clr_before: 0, pop: 1, e_l: 8'hA5, e_m: 8'hA5, e_ovr: 0};
    tbl[1] = '{fl: 4'd0, val: 8'h96, rdy_last: 0, clr_before: 0, pop: 1, e_l: 8'h96, e_m: 8'h69, e_ovr: 0};
    tbl[2] = '{fl: 4'd8, val: 8'h3C, rdy_last: 0, clr_before: 0, pop: 0, e_l: 8'h3C, e_m: 8'h3C, e_ovr: 0};
    tbl[3] = '{fl: 4'd8, val: 8'hC3, rdy_last: 0, clr_before: 0, pop: 0, e_l: 8'h3C, e_m: 8'h3C, e_ovr: 1};
    tbl[4] = '{fl: 4'd8, val: 8'hC3, rdy_last: 1, clr_before: 1, pop: 1, e_l: 8'hC3, e_m: 8'hC3, e_ovr: 0};
    tbl[5] = '{fl: 4'd5, val: 8'h0D, rdy_last: 0, clr_before: 0, pop: 1, e_l: 8'h0D, e_m: 8'h16, e_ovr: 0};
    tbl[6] = '{fl: 4'd9, val: 8'h81, rdy_last: 0, clr_before: 0, pop: 1, e_l: 8'h81, e_m: 8'h81, e_ovr: 0};
    tbl[7] = '{fl: 4'd1, val: 8'h01, rdy_last: 0, clr_before: 0, pop: 1, e_l: 8'h01, e_m: 8'h01, e_ovr: 0};
    tbl[8] = '{fl: 4'd2, val: 8'h02, rdy_last: 0, clr_before: 0, pop: 1, e_l: 8'h02, e_m: 8'h01, e_ovr: 0};

    idle();
    frame_len = 4'd8;
    reset     = 1'b1;
    cycle();
    chk_all_zero("reset");
    reset = 1'b0;
    cycle();

    // Frame-level vectors; frame_len is perturbed after the first bit to prove it is latched.
    for (int r = 0; r < 9; r++) begin
      len_eff = (tbl[r].fl == 0 || tbl[r].fl > 8) ? 8 : int'(tbl[r].fl);
      if (tbl[r].clr_before) begin
        clear = 1'b1;
        cycle();
        clear = 1'b0;
      end
      for (int k = 0; k < len_eff; k++) begin
        frame_len  = (k == 0) ? tbl[r].fl : (tbl[r].fl ^ 4'h3);
        bit_in     = tbl[r].val[k];
        bit_valid  = 1'b1;
        data_ready = (k == len_eff - 1) ? tbl[r].rdy_last : 1'b0;
        cycle();
        if (k != len_eff - 1) begin
          chk("vec busy mid", 32'(busy_l), 1);
          chk("vec bit_count mid", 32'(cnt_l), k + 1);
        end
        bit_valid  = 1'b0;
        data_ready = 1'b0;
        cycle();
      end
      chk("vec lsb data_out", 32'(dout_l), 32'(tbl[r].e_l));
      chk("vec msb data_out", 32'(dout_m), 32'(tbl[r].e_m));
      chk("vec data_valid", 32'(dv_l), 1);
      chk("vec overrun", 32'(ovr_l), 32'(tbl[r].e_ovr));
      chk("vec busy end", 32'(busy_l), 0);
      chk("vec bit_count end", 32'(cnt_l), 0);
      if (tbl[r].pop) begin
        data_ready = 1'b1;
        cycle();
        data_ready = 1'b0;
        chk("vec pop data_valid", 32'(dv_l), 0);
      end
    end

    // clear with a same-cycle bit_valid and handshake
    idle();
    send_bits(4'd8, 32'h5A, 8);
    chk("clr held data", 32'(dout_l), 32'h5A);
    send_bits(4'd8, 32'h3, 3);
    chk("clr partial count", 32'(cnt_l), 3);
    clear      = 1'b1;
    bit_valid  = 1'b1;
    bit_in     = 1'b1;
    data_ready = 1'b1;
    cycle();
    idle();
    chk("clr bit_count", 32'(cnt_l), 0);
    chk("clr busy", 32'(busy_l), 0);
    chk("clr lsb shift_q", 32'(sq_l), 0);
    chk("clr msb shift_q", 32'(sq_m), 0);
    chk("clr handshake data_valid", 32'(dv_l), 0);
    send_bits(4'd8, 32'h5A, 8);
    chk("post clr lsb data_out", 32'(dout_l), 32'h5A);
    chk("post clr msb data_out", 32'(dout_m), 32'h5A);
    chk("post clr data_valid", 32'(dv_l), 1);

    // reset mid-frame while holding data with overrun set
    send_bits(4'd8, 32'h3C, 8);
    chk("pre rst overrun", 32'(ovr_l), 1);
    send_bits(4'd8, 32'hF, 4);
    chk("pre rst bit_count", 32'(cnt_l), 4);
    reset     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    cycle();
    idle();
    chk_all_zero("mid rst");
    send_bits(4'd8, 32'hFF, 8);
    chk("post rst lsb data_out", 32'(dout_l), 32'hFF);
    chk("post rst msb data_out", 32'(dout_m), 32'hFF);
    chk("post rst data_valid", 32'(dv_l), 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(63) == 0);
      clear      = ($urandom_range(31) == 0);
      bit_valid  = 1'($urandom_range(1));
      bit_in     = 1'($urandom_range(1));
      data_ready = ($urandom_range(3) == 0);
      frame_len  = 4'($urandom_range(15));
      cycle();
    end
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_frame_deserializer.md
Name: sipo_frame_deserializer

Overview:
Parameterised serial-in/parallel-out receive shifter, the successor to the fixed-width hold/shift SIPO unit in the UART receive path. It accumulates sampled serial bits and counts them against a runtime frame length. Each completed frame moves into an output holding register with a valid/ready handshake and overrun detection. It sits between the receive bit sampler (bit_valid strobes) and the receive FIFO / CPU interface.

Parameters:
WIDTH, 8, maximum frame length in bits and width of all parallel data paths (legal 2..32).
LSB_FIRST, 1, 1: first received bit lands in bit 0 (UART order); 0: first received bit lands in bit frame_len-1 (MSB-first).
CNT_W, $clog2(WIDTH+1), width of bit counter and frame_len; derived, never overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
bit_in  input  1  serial data bit, sampled only when bit_valid=1.
bit_valid  input  1  one-cycle strobe: accept bit_in this cycle.
frame_len  input  CNT_W  bits per frame; latched on the first bit of each frame.
clear  input  1  aborts the partial frame and clears overrun; does not touch the holding register.
shift_q  output  WIDTH  live contents of the shift register, for debug.
bit_count  output  CNT_W  bits accepted in the current frame.
busy  output  1  1 while a frame is partially received (bit_count != 0).
data_out  output  WIDTH  completed frame, right-aligned, unused upper bits 0.
data_valid  output  1  holding register contains an unconsumed frame.
data_ready  input  1  consumer accepts data_out when data_valid & data_ready.
overrun  output  1  sticky: a completed frame was dropped because the holding register was full.

Behaviour:
- Reset is synchronous, active-high, and applies on the clk edge. All outputs go to 0: shift_q, bit_count, busy, data_out, data_valid, overrun. Reset mid-frame discards all state.
- Effective length L = frame_len, except frame_len=0 or frame_len>WIDTH gives L=WIDTH. L is latched when bit_valid arrives with bit_count=0. Changing frame_len mid-frame has no effect until the next frame.
- States:
  - IDLE (bit_count=0): bit_valid → COLLECT, bit_count=1. If L=1, go straight to completion instead.
  - COLLECT: each bit_valid increments bit_count. No bit_valid → hold all state; there is no timeout.
  - Completion: on the bit_valid that makes the count equal L, bit_count returns to 0 (IDLE) on the same edge.
- Bit placement:
  - LSB_FIRST=1: bit k of the frame (k=0 first) goes to position k.
  - LSB_FIRST=0: bit k goes to position L-1-k.
  - Positions >= L are always 0 in data_out.
  - shift_q shows partial data in the same placement.
- Latency: the frame appears on data_out with data_valid=1 on the edge that consumes its last bit, i.e. visible the cycle after the final bit_valid.
- Handshake:
  - data_valid falls on the edge where data_valid & data_ready, unless a new frame completes on that same edge.
  - data_out is stable while data_valid=1 and not accepted.
- Completion while data_valid=1:
  - data_ready=1 on that cycle: the old frame is consumed, the new frame loads, data_valid stays 1, no overrun.
  - data_ready=0: the new frame is dropped, the old data_out is retained, overrun is set to 1.
- overrun clears only on reset or clear.
- clear:
  - bit_count=0, shift_q=0, overrun=0.
  - A bit_valid in the same cycle is discarded; clear wins.
  - A handshake in the same cycle still completes normally.
- bit_valid while reset=1: ignored.

Test Plan:
- WIDTH=8, LSB_FIRST=1, frame_len=8, bits 1,0,1,0,0,1,0,1 with data_ready=0 → after the 8th bit data_out=8'hA5, data_valid=1, busy=0. Pulse data_ready → data_valid=0 next cycle.
- LSB_FIRST=0, frame_len=5, bits 1,0,1,1,0 → data_out=8'h16, bits 7:5 zero. Then frame_len=0 with 8 bits → treated as 8-bit frame.
- Frame 8'h3C held unconsumed, second frame 8'hC3 completes with data_ready=0 → data_out stays 8'h3C, overrun=1.
- Repeat the previous case with data_ready=1 on the completion cycle → data_out=8'hC3, data_valid stays 1, overrun=0.
- 3 bits received, then clear together with bit_valid → bit_count=0, busy=0, shift_q=0. A following full 8-bit frame 8'h5A is received correctly.
- Reset asserted mid-frame (bit_count=4) while data_valid=1 and overrun=1 → next cycle every output is 0. Frame_len=8 then yields a correct fresh 8'hFF.
